count_bcd_display: RTL and testbench
====================================

Name: count_bcd_display

Overview:
- Downstream consumer of the binary up-counter output.
- Takes an unsigned count of up to 6 bits and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives two 7-segment digit patterns for the board display.
- Handshake: start/busy/done, so the counter's `out` can be sampled on demand.

Parameters:
- WIDTH, 6, bit width of value_in. Legal range 2..6; maximum value 63 fits in two digits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- value_in  in  WIDTH  unsigned count to convert; sampled only when start is accepted.
- start  in  1  request conversion; level-sampled in IDLE.
- busy  out  1  high while a conversion is in progress (SHIFT and DONE states).
- done  out  1  one-cycle pulse when new results are valid.
- tens  out  4  BCD tens digit, range 0..6.
- units  out  4  BCD units digit, range 0..9.
- seg_tens  out  7  active-low segments {g,f,e,d,c,b,a} for tens.
- seg_units  out  7  active-low segments {g,f,e,d,c,b,a} for units.

Behaviour:
- Reset (reset=0, asynchronous) applies regardless of state, including mid-conversion:
  - state=IDLE, busy=0, done=0, tens=0, units=0.
  - seg_units=7'b1000000.
  - seg_tens=7'b1000000, or 7'b1111111 with SEG_BLANK_EN.
  - Internal shift register, scratch digits and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if start=1, capture value_in into the shift register, clear scratch digits, set bit counter to WIDTH, go to SHIFT. Otherwise stay.
  - SHIFT: each cycle, add 3 to any scratch digit >=5, then shift {tens,units,shreg} left by 1 and decrement the counter. When the counter reaches 0 after this shift, go to DONE.
  - DONE: register scratch digits into tens/units and seg_*, assert done for this single cycle, return to IDLE.
- Latency: start accepted at edge N; done high in the cycle after edge N+WIDTH+1. For WIDTH=6, 7 cycles from acceptance to the done pulse.
- start while busy=1 is ignored; no queueing.
- start in the cycle after done (state back in IDLE) is accepted, so back-to-back conversions are supported.
- tens/units/seg_* hold their last result until the next DONE; they never show intermediate shift values.
- Arithmetic: scratch digits are 4 bits; add-3 never overflows for values <=63. value_in is zero-extended internally to 6 bits.
- Segment encoding, digits 0..9, active-low gfedcba: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Any code >9 decodes to 7'b1111111.

Optional Feature:
- Macro: SEG_BLANK_EN (leading-zero blanking).
- Defined: seg_tens=7'b1111111 whenever tens=0, including after reset.
- Undefined: seg_tens always shows the decoded digit, so 0 shows 7'b1000000.
- tens/units BCD outputs are identical in both builds.

Decomposition:
- Package count_display_pkg:
  - state enum typedef (IDLE/SHIFT/DONE).
  - SEG_BLANK constant 7'b1111111.
  - the ten segment pattern constants.
  - BCD digit typedef (logic [3:0]).
- Sub-module bcd_to_seg: combinational 4-bit-to-7-segment decoder, instanced twice.
- Sequential FSM and datapath stay in count_bcd_display.

Test Plan:
- Reset mid-conversion: start with value_in=42, pull reset low after 3 SHIFT cycles -> immediately busy=0, done=0, tens=0, units=0; no done pulse follows release.
- value_in=42, start pulse -> busy for 7 cycles, done pulse once; tens=4, units=2, seg_tens=0011001, seg_units=0100100.
- value_in=63 -> tens=6, units=3. Then value_in=0 -> tens=0, units=0; seg_tens=1111111 with SEG_BLANK_EN, 1000000 without.
- start held high continuously with value_in switching 17 -> 50 during busy -> first result tens=1, units=7; next conversion starts in the IDLE cycle after done.
- WIDTH=2 instance, value_in=3 -> done 3 cycles after acceptance, tens=0, units=3.
- Sweep value_in 0..63 -> each result equals value/10 and value%10, and done pulses exactly once per conversion.

Source files
------------

// File: rtl/count_display_pkg.sv
// Shared types and constants for the BCD count display: FSM states, BCD digit type, segment patterns.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment decoder; codes above 9 blank the digit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module bcd_to_seg
    import count_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Lookup of the segment pattern for one digit
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_bcd_display.sv
// Converts a binary count (<=63) to two BCD digits by sequential double-dabble and drives two 7-seg patterns; SEG_BLANK_EN blanks a zero tens digit.
// Latency: start accepted at edge N, done pulses in the cycle after edge N+WIDTH+1 (7 cycles for WIDTH=6).
// Backpressure: start is ignored while busy; no queueing, a new start is taken the cycle done is high.
module count_bcd_display
    import count_display_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       tens,
    output logic [3:0]       units,
    output logic [6:0]       seg_tens,
    output logic [6:0]       seg_units
);

    // The engine always works on 6 bits; a narrower input is left-aligned so its MSB leaves first.
    localparam int PAD = 6 - WIDTH;

`ifdef SEG_BLANK_EN
    localparam logic [6:0] SEG_TENS_RST = SEG_BLANK;
`else
    localparam logic [6:0] SEG_TENS_RST = SEG_0;
`endif

    state_t     state_q, state_d;
    logic [5:0] shreg_q, shreg_d;
    bcd_t       dig_t_q, dig_t_d;
    bcd_t       dig_u_q, dig_u_d;
    logic [2:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    bcd_t       tens_q, tens_d;
    bcd_t       units_q, units_d;
    logic [6:0] seg_tens_q, seg_tens_d;
    logic [6:0] seg_units_q, seg_units_d;

    logic [5:0] value_ext;
    bcd_t       t_adj;
    bcd_t       u_adj;
    logic [6:0] seg_t_dec;
    logic [6:0] seg_u_dec;

    assign value_ext = 6'(value_in);

    bcd_to_seg u_dec_tens  (.digit(dig_t_q), .seg(seg_t_dec));
    bcd_to_seg u_dec_units (.digit(dig_u_q), .seg(seg_u_dec));

    // State and datapath registers, cleared asynchronously from any state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            dig_t_q     <= '0;
            dig_u_q     <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            tens_q      <= '0;
            units_q     <= '0;
            seg_tens_q  <= SEG_TENS_RST;
            seg_units_q <= SEG_0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            dig_t_q     <= dig_t_d;
            dig_u_q     <= dig_u_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            tens_q      <= tens_d;
            units_q     <= units_d;
            seg_tens_q  <= seg_tens_d;
            seg_units_q <= seg_units_d;
        end
    end

    // Next-state: one SHIFT cycle per input bit, then a single DONE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == 3'd1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: add-3 correction then shift; results only published in DONE
    always_comb begin
        t_adj       = (dig_t_q >= 4'd5) ? dig_t_q + 4'd3 : dig_t_q;
        u_adj       = (dig_u_q >= 4'd5) ? dig_u_q + 4'd3 : dig_u_q;
        shreg_d     = shreg_q;
        dig_t_d     = dig_t_q;
        dig_u_d     = dig_u_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        tens_d      = tens_q;
        units_d     = units_q;
        seg_tens_d  = seg_tens_q;
        seg_units_d = seg_units_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = value_ext << PAD;
                    dig_t_d = '0;
                    dig_u_d = '0;
                    cnt_d   = 3'(WIDTH);
                end
            end
            SHIFT: begin
                {dig_t_d, dig_u_d, shreg_d} = {t_adj, u_adj, shreg_q} << 1;
                cnt_d = cnt_q - 3'd1;
            end
            DONE: begin
                tens_d      = dig_t_q;
                units_d     = dig_u_q;
                seg_units_d = seg_u_dec;
`ifdef SEG_BLANK_EN
                seg_tens_d  = (dig_t_q == 4'd0) ? SEG_BLANK : seg_t_dec;
`else
                seg_tens_d  = seg_t_dec;
`endif
                done_d      = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs: busy follows state, everything else straight from registers
    always_comb begin
        busy      = (state_q != IDLE);
        done      = done_q;
        tens      = tens_q;
        units     = units_q;
        seg_tens  = seg_tens_q;
        seg_units = seg_units_q;
    end

endmodule

// File: tb/tb_count_bcd_display.sv
module tb_count_bcd_display;

    localparam logic [6:0] SEG_REF [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
`ifdef SEG_BLANK_EN
    localparam logic [6:0] ZERO_TENS = 7'b1111111;
`else
    localparam logic [6:0] ZERO_TENS = 7'b1000000;
`endif

    typedef struct {
        int         v;
        int         t;
        int         u;
        logic [6:0] st;
        logic [6:0] su;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [5:0] value_in;
    logic       start;
    logic       busy, done;
    logic [3:0] tens, units;
    logic [6:0] seg_tens, seg_units;

    logic [1:0] value2;
    logic       start2;
    logic       busy2, done2;
    logic [3:0] tens2, units2;
    logic [6:0] seg_tens2, seg_units2;

    int n_checks = 0;
    int n_fail   = 0;

    count_bcd_display #(.WIDTH(6)) dut (
        .clk(clk), .reset(reset), .value_in(value_in), .start(start),
        .busy(busy), .done(done), .tens(tens), .units(units),
        .seg_tens(seg_tens), .seg_units(seg_units)
    );

    count_bcd_display #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .value_in(value2), .start(start2),
        .busy(busy2), .done(done2), .tens(tens2), .units(units2),
        .seg_tens(seg_tens2), .seg_units(seg_units2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg_tens(input int d);
        return (d == 0) ? ZERO_TENS : SEG_REF[d];
    endfunction

    // Reference: decimal digits of v from plain arithmetic
    task automatic check_result(input string nm, input int v);
        chk({nm, "_tens"}, int'(tens), v / 10);
        chk({nm, "_units"}, int'(units), v % 10);
        chk({nm, "_seg_tens"}, int'(seg_tens), int'(exp_seg_tens(v / 10)));
        chk({nm, "_seg_units"}, int'(seg_units), int'(SEG_REF[v % 10]));
    endtask

    // One start pulse on the 6-bit DUT; returns cycles from acceptance edge to done sample
    task automatic conv6(input int v, output int lat);
        int   prev_t, prev_u;
        logic held;
        prev_t   = int'(tens);
        prev_u   = int'(units);
        held     = 1'b1;
        value_in = 6'(v);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy !== 1'b1 || int'(tens) != prev_t || int'(units) != prev_u) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 7);
        chk("busy_hold", int'(held), 1);
        chk("busy_at_done", int'(busy), 0);
    endtask

    initial begin
        vec_t vecs[6];
        int   lat;
        int   seen;

        vecs[0] = '{42, 4, 2, 7'b0011001, 7'b0100100};
        vecs[1] = '{63, 6, 3, 7'b0000010, 7'b0110000};
        vecs[2] = '{0,  0, 0, ZERO_TENS,  7'b1000000};
        vecs[3] = '{9,  0, 9, ZERO_TENS,  7'b0010000};
        vecs[4] = '{10, 1, 0, 7'b1111001, 7'b1000000};
        vecs[5] = '{57, 5, 7, 7'b0010010, 7'b1111000};

        reset = 1'b0; start = 1'b0; value_in = '0; start2 = 1'b0; value2 = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tens", int'(tens), 0);
        chk("rst_units", int'(units), 0);
        chk("rst_seg_tens", int'(seg_tens), int'(ZERO_TENS));
        chk("rst_seg_units", int'(seg_units), 7'b1000000);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            conv6(vecs[i].v, lat);
            chk("tbl_tens", int'(tens), vecs[i].t);
            chk("tbl_units", int'(units), vecs[i].u);
            chk("tbl_seg_tens", int'(seg_tens), int'(vecs[i].st));
            chk("tbl_seg_units", int'(seg_units), int'(vecs[i].su));
            @(posedge clk); #1;
            chk("tbl_done_once", int'(done), 0);
        end

        // Reset in the middle of a conversion (results currently 57)
        value_in = 6'd42; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_tens", int'(tens), 0);
        chk("midrst_units", int'(units), 0);
        chk("midrst_seg_tens", int'(seg_tens), int'(ZERO_TENS));
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("midrst_no_done", seen, 0);

        // start held high, value changes while busy, back-to-back conversion
        value_in = 6'd17; start = 1'b1;
        @(posedge clk); #1;
        value_in = 6'd50;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("held_latency", lat, 7);
        check_result("held_first", 17);
        @(posedge clk); #1;
        chk("held_rearm_busy", int'(busy), 1);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("held2_latency", lat, 7);
        check_result("held_second", 50);
        @(posedge clk); #1;

        // WIDTH=2 instance
        for (int v = 0; v < 4; v++) begin
            value2 = 2'(v); start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            lat = 0;
            while (done2 !== 1'b1 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("w2_latency", lat, 3);
            chk("w2_tens", int'(tens2), 0);
            chk("w2_units", int'(units2), v);
            chk("w2_seg_units", int'(seg_units2), int'(SEG_REF[v]));
            chk("w2_seg_tens", int'(seg_tens2), int'(ZERO_TENS));
            @(posedge clk); #1;
            chk("w2_done_once", int'(done2), 0);
        end

        // Full sweep
        for (int v = 0; v < 64; v++) begin
            conv6(v, lat);
            check_result("sweep", v);
            @(posedge clk); #1;
            chk("sweep_done_once", int'(done), 0);
        end

        // Random values with random idle gaps
        for (int k = 0; k < 30; k++) begin
            int v;
            v = int'($urandom_range(63));
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
            conv6(v, lat);
            check_result("rand", v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
